// File: rtl/tvip_axi_burst_address_gen_if.sv
// Command/beat bus of the AXI burst beat-address generator.
// The master side issues burst commands and consumes beats; the slave side
// (the generator) accepts commands and produces one beat per transfer.
interface tvip_axi_burst_address_gen_if #(
   parameter int ADDRESS_WIDTH = 64,
   parameter int DATA_WIDTH    = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic                     req_valid;
   logic                     req_ready;
   logic [ADDRESS_WIDTH-1:0] req_address;
   logic [7:0]               req_length;
   logic [2:0]               req_size;
   logic [1:0]               req_burst;
   logic                     beat_valid;
   logic                     beat_ready;
   logic [ADDRESS_WIDTH-1:0] beat_address;
   logic [7:0]               beat_index;
   logic                     beat_last;
   logic [BYTES-1:0]         beat_strobe;
   logic                     cmd_error;

   modport master (
      output req_valid, req_address, req_length, req_size, req_burst, beat_ready,
      input  req_ready, beat_valid, beat_address, beat_index, beat_last, beat_strobe, cmd_error
   );

   modport slave (
      input  req_valid, req_address, req_length, req_size, req_burst, beat_ready,
      output req_ready, beat_valid, beat_address, beat_index, beat_last, beat_strobe, cmd_error
   );
endinterface

// File: rtl/tvip_axi_burst_address_gen.sv
// Sequential AXI4 beat-address generator: takes one burst command
// (address, length, size, type), checks it, then walks the burst beat by
// beat producing address, index, last flag and byte-lane strobe.
module tvip_axi_burst_address_gen #(
   parameter int ADDRESS_WIDTH = 64,
   parameter int DATA_WIDTH    = 32
) (
   input logic                    aclk,
   input logic                    areset_n,
   tvip_axi_burst_address_gen_if.slave bus
);
   localparam int         BYTES    = DATA_WIDTH / 8;
   localparam logic [3:0] MAX_SIZE = 4'($clog2(BYTES));

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_ERROR = 2'd2;

   localparam logic [1:0] BT_FIXED = 2'b00;
   localparam logic [1:0] BT_INCR  = 2'b01;
   localparam logic [1:0] BT_WRAP  = 2'b10;
   localparam logic [1:0] BT_RSVD  = 2'b11;

   typedef logic [ADDRESS_WIDTH-1:0] addr_t;

   logic [1:0] state_reg, state_next;
   logic       ready_reg;
   addr_t      address_reg;
   addr_t      aligned_reg;
   logic [7:0] index_reg;
   logic [7:0] length_reg;
   logic [2:0] size_reg;
   logic [1:0] burst_reg;

   // Command decode and legality, evaluated on the incoming request.
   addr_t req_nbytes, req_aligned, req_total, req_end;
   logic  wrap_len_ok, req_illegal, accept;

   assign req_nbytes  = addr_t'(1) << bus.req_size;
   assign req_aligned = bus.req_address & ~(req_nbytes - addr_t'(1));
   assign req_total   = addr_t'({1'b0, bus.req_length} + 9'd1) << bus.req_size;
   assign req_end     = req_aligned + req_total - addr_t'(1);
   assign wrap_len_ok = (bus.req_length == 8'd1) || (bus.req_length == 8'd3) ||
                        (bus.req_length == 8'd7) || (bus.req_length == 8'd15);
   assign req_illegal = (bus.req_burst == BT_RSVD) ||
                        ({1'b0, bus.req_size} > MAX_SIZE) ||
                        ((bus.req_burst == BT_WRAP) && !wrap_len_ok) ||
                        ((bus.req_burst == BT_WRAP) && (bus.req_address != req_aligned)) ||
                        ((bus.req_burst == BT_INCR) &&
                         ((bus.req_address >> 12) != (req_end >> 12)));
   assign accept      = (state_reg == ST_IDLE) && ready_reg && bus.req_valid;

   // Per-beat address arithmetic on the registered command.
   addr_t cur_nbytes, cur_total, cur_aligned, incr_next, wrap_lower, wrap_next;
   addr_t next_address, lane_lo, lane_hi;
   logic  beat_hs, is_last, in_burst;

   assign in_burst    = (state_reg == ST_BURST);
   assign beat_hs     = in_burst && bus.beat_ready;
   assign is_last     = (index_reg == length_reg);
   assign cur_nbytes  = addr_t'(1) << size_reg;
   assign cur_total   = addr_t'({1'b0, length_reg} + 9'd1) << size_reg;
   assign cur_aligned = address_reg & ~(cur_nbytes - addr_t'(1));
   assign incr_next   = aligned_reg + ((addr_t'(index_reg) + addr_t'(1)) << size_reg);
   assign wrap_lower  = address_reg & ~(cur_total - addr_t'(1));
   assign wrap_next   = wrap_lower + ((address_reg + cur_nbytes) & (cur_total - addr_t'(1)));

   // Select the address of the following beat from the burst type.
   always_comb begin
      next_address = address_reg;
      case (burst_reg)
         BT_INCR: next_address = incr_next;
         BT_WRAP: next_address = wrap_next;
         default: next_address = address_reg;
      endcase
   end

   // Byte lanes: from the (possibly unaligned) beat offset up to the end of
   // the size-aligned container within the bus word.
   assign lane_lo = address_reg & addr_t'(BYTES - 1);
   assign lane_hi = (cur_aligned & addr_t'(BYTES - 1)) + cur_nbytes - addr_t'(1);

   for (genvar gi = 0; gi < BYTES; gi++) begin : g_strobe
      assign bus.beat_strobe[gi] = in_burst &&
                                   (addr_t'(gi) >= lane_lo) && (addr_t'(gi) <= lane_hi);
   end

   // Next-state logic: IDLE accepts, BURST walks beats, ERROR is a single pulse.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = req_illegal ? ST_ERROR : ST_BURST;
         ST_BURST: if (beat_hs && is_last) state_next = ST_IDLE;
         ST_ERROR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State, command and beat registers; reset discards any burst in flight.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_reg   <= ST_IDLE;
         ready_reg   <= 1'b0;
         address_reg <= '0;
         aligned_reg <= '0;
         index_reg   <= '0;
         length_reg  <= '0;
         size_reg    <= '0;
         burst_reg   <= '0;
      end else begin
         state_reg <= state_next;
         // req_ready is registered so it only rises one edge after reset release
         ready_reg <= (state_next == ST_IDLE);
         if (accept && !req_illegal) begin
            address_reg <= bus.req_address;
            aligned_reg <= req_aligned;
            index_reg   <= 8'd0;
            length_reg  <= bus.req_length;
            size_reg    <= bus.req_size;
            burst_reg   <= bus.req_burst;
         end else if (beat_hs && !is_last) begin
            address_reg <= next_address;
            index_reg   <= index_reg + 8'd1;
         end
      end
   end

   assign bus.req_ready    = ready_reg;
   assign bus.beat_valid   = in_burst;
   assign bus.beat_address = address_reg;
   assign bus.beat_index   = index_reg;
   assign bus.beat_last    = in_burst && is_last;
   assign bus.cmd_error    = (state_reg == ST_ERROR);
endmodule

// File: tb/tb_tvip_axi_burst_address_gen.sv
// Directed bench for the AXI burst beat-address generator: a table of
// commands with hand-computed beats, plus backpressure and mid-burst reset.
module tb_tvip_axi_burst_address_gen;
   localparam int AW = 64;
   localparam int DW = 32;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;

   always #5 aclk = ~aclk;

   tvip_axi_burst_address_gen_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   tvip_axi_burst_address_gen #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .bus      (bus)
   );

   typedef struct packed {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic             err;
      logic [7:0][31:0] exp_addr;
      logic [7:0][3:0]  exp_strb;
   } vec_t;

   vec_t vecs [12];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [7:0][31:0] A(input logic [31:0] a0 = 0, a1 = 0, a2 = 0,
                                          a3 = 0, a4 = 0, a5 = 0, a6 = 0, a7 = 0);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [7:0][3:0] S(input logic [3:0] s0 = 0, s1 = 0, s2 = 0,
                                         s3 = 0, s4 = 0, s5 = 0, s6 = 0, s7 = 0);
      return {s7, s6, s5, s4, s3, s2, s1, s0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int waited;
      @(negedge aclk);
      bus.req_valid   = 1'b1;
      bus.req_address = 64'(addr);
      bus.req_length  = len;
      bus.req_size    = size;
      bus.req_burst   = burst;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge aclk);
         waited++;
      end
      check("req_ready_wait", 64'(bus.req_ready), 64'(1));
      @(posedge aclk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      bus.beat_ready = 1'b1;
      issue(v.addr, v.len, v.size, v.burst);
      if (v.err) begin
         @(negedge aclk);
         check("err_pulse", 64'(bus.cmd_error), 64'(1));
         check("err_no_beat", 64'(bus.beat_valid), 64'(0));
         $display("vec %0d: addr 0x%0h len %0d size %0d burst %0d -> cmd_error=%0b",
                  id, v.addr, v.len, v.size, v.burst, bus.cmd_error);
         @(negedge aclk);
         check("err_clear", 64'(bus.cmd_error), 64'(0));
         check("err_no_beat2", 64'(bus.beat_valid), 64'(0));
         check("err_ready", 64'(bus.req_ready), 64'(1));
      end else begin
         for (int b = 0; b <= int'(v.len); b++) begin
            @(negedge aclk);
            check("beat_valid", 64'(bus.beat_valid), 64'(1));
            check("beat_address", bus.beat_address, 64'(v.exp_addr[b]));
            check("beat_index", 64'(bus.beat_index), 64'(b));
            check("beat_last", 64'(bus.beat_last), 64'(b == int'(v.len)));
            check("beat_strobe", 64'(bus.beat_strobe), 64'(v.exp_strb[b]));
            $display("vec %0d beat %0d: addr 0x%0h strb %b last %0b",
                     id, b, bus.beat_address, bus.beat_strobe, bus.beat_last);
         end
         @(negedge aclk);
         check("post_valid", 64'(bus.beat_valid), 64'(0));
         check("post_ready", 64'(bus.req_ready), 64'(1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int cyc;

      vecs[0]  = '{32'h1002, 8'd3, 3'd2, 2'b01, 1'b0,
                   A(32'h1002, 32'h1004, 32'h1008, 32'h100C),
                   S(4'b1100, 4'b1111, 4'b1111, 4'b1111)};
      vecs[1]  = '{32'h0038, 8'd3, 3'd2, 2'b10, 1'b0,
                   A(32'h38, 32'h3C, 32'h30, 32'h34),
                   S(4'b1111, 4'b1111, 4'b1111, 4'b1111)};
      vecs[2]  = '{32'h0022, 8'd2, 3'd1, 2'b00, 1'b0,
                   A(32'h22, 32'h22, 32'h22),
                   S(4'b1100, 4'b1100, 4'b1100)};
      vecs[3]  = '{32'h0010, 8'd1, 3'd0, 2'b01, 1'b0,
                   A(32'h10, 32'h11), S(4'b0001, 4'b0010)};
      vecs[4]  = '{32'h0006, 8'd7, 3'd0, 2'b10, 1'b0,
                   A(32'h6, 32'h7, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5),
                   S(4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010)};
      vecs[5]  = '{32'h0FFC, 8'd0, 3'd2, 2'b01, 1'b0, A(32'hFFC), S(4'b1111)};
      vecs[6]  = '{32'h0FF8, 8'd3, 3'd2, 2'b01, 1'b1, A(), S()};
      vecs[7]  = '{32'h0000, 8'd2, 3'd2, 2'b10, 1'b1, A(), S()};
      vecs[8]  = '{32'h0000, 8'd0, 3'd2, 2'b11, 1'b1, A(), S()};
      vecs[9]  = '{32'h0000, 8'd0, 3'd3, 2'b01, 1'b1, A(), S()};
      vecs[10] = '{32'h0032, 8'd3, 3'd2, 2'b10, 1'b1, A(), S()};
      vecs[11] = '{32'h1003, 8'd1, 3'd1, 2'b01, 1'b0,
                   A(32'h1003, 32'h1004), S(4'b1000, 4'b0011)};

      bus.req_valid   = 1'b0;
      bus.req_address = '0;
      bus.req_length  = '0;
      bus.req_size    = '0;
      bus.req_burst   = '0;
      bus.beat_ready  = 1'b1;

      // Reset values while held in reset
      @(negedge aclk);
      @(negedge aclk);
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_beat_valid", 64'(bus.beat_valid), 64'(0));
      check("rst_beat_last", 64'(bus.beat_last), 64'(0));
      check("rst_cmd_error", 64'(bus.cmd_error), 64'(0));
      check("rst_beat_address", bus.beat_address, 64'(0));
      check("rst_beat_index", 64'(bus.beat_index), 64'(0));
      check("rst_beat_strobe", 64'(bus.beat_strobe), 64'(0));
      @(posedge aclk);
      #1 areset_n = 1'b1;
      @(negedge aclk);
      check("rel_ready_low", 64'(bus.req_ready), 64'(0));
      @(negedge aclk);
      check("rel_ready_high", 64'(bus.req_ready), 64'(1));
      $display("reset released, req_ready=%0b", bus.req_ready);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Backpressure: INCR 8 beats with random beat_ready
      bus.beat_ready = 1'b0;
      issue(32'h2000, 8'd7, 3'd2, 2'b01);
      hs  = 0;
      cyc = 0;
      while (hs < 8 && cyc < 200) begin
         @(negedge aclk);
         cyc++;
         check("bp_valid", 64'(bus.beat_valid), 64'(1));
         check("bp_address", bus.beat_address, 64'(32'h2000 + 4 * hs));
         check("bp_index", 64'(bus.beat_index), 64'(hs));
         check("bp_last", 64'(bus.beat_last), 64'(hs == 7));
         check("bp_strobe", 64'(bus.beat_strobe), 64'(4'b1111));
         bus.beat_ready = 1'($urandom_range(0, 1));
         $display("bp cycle %0d: addr 0x%0h idx %0d ready %0b",
                  cyc, bus.beat_address, bus.beat_index, bus.beat_ready);
         if (bus.beat_ready) hs++;
      end
      check("bp_handshakes", 64'(hs), 64'(8));
      bus.beat_ready = 1'b1;
      @(negedge aclk);
      check("bp_done_valid", 64'(bus.beat_valid), 64'(0));
      check("bp_done_ready", 64'(bus.req_ready), 64'(1));
      @(negedge aclk);
      check("bp_no_extra", 64'(bus.beat_valid), 64'(0));

      // Reset asserted during beat 2 of 4
      bus.beat_ready = 1'b1;
      issue(32'h3000, 8'd3, 3'd2, 2'b01);
      @(negedge aclk);
      @(negedge aclk);
      @(negedge aclk);
      check("mr_index", 64'(bus.beat_index), 64'(2));
      check("mr_address", bus.beat_address, 64'(32'h3008));
      #2 areset_n = 1'b0;
      #1;
      check("mr_valid", 64'(bus.beat_valid), 64'(0));
      check("mr_addr_clr", bus.beat_address, 64'(0));
      check("mr_index_clr", 64'(bus.beat_index), 64'(0));
      check("mr_strobe_clr", 64'(bus.beat_strobe), 64'(0));
      check("mr_last_clr", 64'(bus.beat_last), 64'(0));
      check("mr_cmd_error", 64'(bus.cmd_error), 64'(0));
      $display("reset mid-burst: beat_valid=%0b", bus.beat_valid);
      @(posedge aclk);
      #1;
      @(posedge aclk);
      #1 areset_n = 1'b1;
      @(negedge aclk);
      check("mr_rel_ready_low", 64'(bus.req_ready), 64'(0));
      check("mr_rel_err", 64'(bus.cmd_error), 64'(0));
      @(negedge aclk);
      check("mr_rel_ready", 64'(bus.req_ready), 64'(1));
      check("mr_rel_valid", 64'(bus.beat_valid), 64'(0));
      run_vec(0, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
